// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational instruction ROM between the CPU fetch
// port (master 0, high priority) and a secondary reader (master 1).
// Master 1 gets a forced grant after MAX_WAIT denied cycles. Read data is
// registered, so each master sees a one-cycle read latency. stall_req_o tells
// the CPU pipeline when its fetch has been denied.
// Optional feature macro: ROM_ARB_LOCK_EN adds an m1_lock input. While m1_lock
// is held, master 1 keeps exclusive ownership of the ROM.
module rom_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3    // legal values are 1 to 15
) (
  input  logic              clk,
  input  logic              rst,          // synchronous, active low
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
`ifdef ROM_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              stall_req_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

`ifdef ROM_ARB_LOCK_EN
  typedef enum logic { ARB_NORMAL = 1'b0, ARB_LOCKED = 1'b1 } arb_state_e;
`else
  typedef enum logic { ARB_NORMAL = 1'b0 } arb_state_e;
`endif

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             m0_rvalid_q, m1_rvalid_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic             starve;

  // Arbitration state, starvation counter and registered read responses.
  // NOTE: reset is sampled on the clock edge only, so it sits inside the
  // posedge block and is not in the sensitivity list. All state uses
  // non-blocking assignments, so every register reads the pre-edge values of
  // the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_NORMAL;
      wait_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      m0_rvalid_q <= m0_gnt;
      m1_rvalid_q <= m1_gnt;
      if (m0_gnt) m0_rdata_q <= rom_data_i;
      if (m1_gnt) m1_rdata_q <= rom_data_i;
    end
  end

  // Grant decision, next state and next wait count. Everything is forced idle
  // while reset is held.
  // NOTE: every signal gets a default first so that no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    starve     = 1'b0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    if (rst) begin
      case (state_q)
        ARB_NORMAL: begin
          starve = m1_req && (wait_cnt_q == MAX_CNT);
          m1_gnt = m1_req && (!m0_req || starve);
          m0_gnt = m0_req && !m1_gnt;
          if (m1_req && !m1_gnt) begin
            wait_cnt_d = (wait_cnt_q == MAX_CNT) ? wait_cnt_q
                                                 : wait_cnt_q + CNT_W'(1);
          end
`ifdef ROM_ARB_LOCK_EN
          if (m1_gnt && m1_lock) state_d = ARB_LOCKED;
`endif
        end
`ifdef ROM_ARB_LOCK_EN
        ARB_LOCKED: begin
          // Master 1 owns the ROM; the starvation count stays at zero.
          m1_gnt = m1_req;
          if (!m1_lock) state_d = ARB_NORMAL;
        end
`endif
        default: state_d = ARB_NORMAL;
      endcase
    end
  end

  // ROM side: the chosen master's address is passed through combinationally.
  always_comb begin
    rom_ce_o    = m0_gnt | m1_gnt;
    rom_addr_o  = m1_gnt ? m1_addr : (m0_gnt ? m0_addr : '0);
    stall_req_o = rst && m0_req && !m0_gnt;
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single combinational instruction ROM between two requesters.
  - Master 0: the CPU fetch port, normally high priority.
  - Master 1: a secondary reader such as a program loader, debug port or data-side ROM read.
- Sits in the minimal SOPC between the CPU/secondary master and the ROM, replacing the direct CPU-to-ROM connection.
- Fixed priority to master 0, with a starvation guard that forces a master-1 grant after a bounded wait.
- Registers ROM read data, so every master sees one-cycle read latency; raises a stall request to the CPU pipeline when a fetch is denied.

Parameters:
- ADDR_W, 32, address width; matches the instruction address bus.
- DATA_W, 32, data width; matches the instruction bus.
- MAX_WAIT, 3, cycles master 1 may be denied before a forced grant; legal values 1 to 15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- m0_req  in  1  CPU fetch request.
- m0_addr  in  ADDR_W  CPU fetch address.
- m0_gnt  out  1  CPU request accepted this cycle (combinational).
- m0_rvalid  out  1  m0_rdata valid (registered).
- m0_rdata  out  DATA_W  read data for master 0.
- m1_req  in  1  secondary read request.
- m1_addr  in  ADDR_W  secondary read address.
- m1_gnt  out  1  secondary request accepted this cycle (combinational).
- m1_rvalid  out  1  m1_rdata valid (registered).
- m1_rdata  out  DATA_W  read data for master 1.
- rom_ce_o  out  1  ROM chip enable.
- rom_addr_o  out  ADDR_W  ROM address.
- rom_data_i  in  DATA_W  ROM read data; combinational from rom_addr_o.
- stall_req_o  out  1  to CPU control: fetch denied this cycle.

Behaviour:
- Reset (rst==0 at a clock edge):
  - m0_rvalid, m1_rvalid, m0_rdata, m1_rdata and wait_cnt clear to 0; FSM goes to ARB_NORMAL.
  - While rst==0, all grants, rom_ce_o and stall_req_o are forced to 0 and rom_addr_o is 0.
- Starvation: starve = m1_req && (wait_cnt == MAX_WAIT).
- Grant in ARB_NORMAL:
  - m1_gnt = m1_req && (!m0_req || starve).
  - m0_gnt = m0_req && !m1_gnt.
  - The two grants are never high together.
- ROM side:
  - rom_ce_o = m0_gnt | m1_gnt.
  - rom_addr_o = m1_addr when m1_gnt, m0_addr when m0_gnt, otherwise 0.
- Response, one cycle after grant:
  - mX_rvalid <= mX_gnt.
  - mX_rdata <= rom_data_i when mX_gnt, else holds its previous value.
  - Back-to-back grants to one master give rvalid every cycle.
- wait_cnt (width sized to hold MAX_WAIT):
  - Increments, saturating at MAX_WAIT, when m1_req && !m1_gnt.
  - Clears when m1_gnt or !m1_req.
- Fairness: with both masters requesting continuously, master 1 is granted in the (MAX_WAIT+1)th cycle of its wait; master 0 is then served for MAX_WAIT cycles; the pattern repeats.
- stall_req_o = m0_req && !m0_gnt.
- Request rules:
  - Requesters hold req until granted.
  - The address is sampled only in the grant cycle; changing it while waiting is legal.
  - Dropping req before grant withdraws the request silently.
- Reset mid-operation: any response in flight is lost (rvalid 0 next cycle); the wait count restarts from 0.

Optional Feature:
- Macro: ROM_ARB_LOCK_EN.
- When defined:
  - Extra input m1_lock (1 bit) is added.
  - When m1_gnt && m1_lock, the FSM moves ARB_NORMAL to ARB_LOCKED.
  - In ARB_LOCKED, m0_gnt=0 and m1_gnt=m1_req; the starvation counter holds at 0.
  - The FSM returns to ARB_NORMAL in the cycle after m1_lock samples 0.
  - Reset forces ARB_NORMAL.
- When not defined: no m1_lock port, no ARB_LOCKED state, behaviour exactly as above.

Test Plan:
- Reset: rst=0 with m0_req=m1_req=1 for 3 cycles -> grants 0, rom_ce_o 0, stall_req_o 0, both rvalid 0.
- m0 only, m0_addr=0x00000004, ROM returns 0x34011100 -> m0_gnt=1 and rom_addr_o=0x00000004 same cycle; next cycle m0_rvalid=1, m0_rdata=0x34011100.
- Both requesting continuously, MAX_WAIT=3:
  - m0 granted cycles 1-3, m1 granted cycle 4, m0 cycles 5-7, m1 cycle 8.
  - stall_req_o=1 only in cycles 4 and 8.
  - m1_rvalid=1 in cycles 5 and 9.
- m1 only, m1_addr=0x00000010 -> m1_gnt same cycle; m1_rvalid next cycle; stall_req_o stays 0; wait_cnt stays 0.
- Both requesting, rst pulsed low for one cycle when wait_cnt=2 -> after reset, m1 granted only after 3 further denied cycles; any pending rvalid is 0.
- With ROM_ARB_LOCK_EN, m1_lock=1 at m1's grant, m0 requesting -> m0 denied and stall_req_o=1 for every cycle m1_lock stays 1; m0 granted the cycle after m1_lock=0 is sampled.
